// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR serial-MAC tap sequencer.
package fir_seq_pkg;

    localparam int unsigned DEF_TAPS = 33;
    localparam int unsigned PHASE_W  = $clog2(DEF_TAPS);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        MAC,
        DRAIN,
        OUTPUT
    } state_e;

    // Half an LSB of the result after an arithmetic right shift by 'shift'.
    function automatic logic [63:0] round_const(input int unsigned shift);
        return 64'd1 << (shift - 1);
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and saturate an accumulator down to sample width.
module fir_round_sat
    import fir_seq_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SHIFT     = 15
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [WIDTH-1:0]     sat_o
);

    localparam int unsigned EXT_W = ACC_WIDTH + 1;
    localparam logic [EXT_W-1:0] HALF = EXT_W'(round_const(SHIFT));

    logic signed [EXT_W-1:0] sum_c;
    logic signed [EXT_W-1:0] shr_c;
    logic                    pos_ovf_c;
    logic                    neg_ovf_c;

    // One guard bit keeps the rounding add from wrapping.
    always_comb begin
        sum_c     = $signed({acc_i[ACC_WIDTH-1], acc_i}) + $signed(HALF);
        shr_c     = sum_c >>> SHIFT;
        pos_ovf_c = !shr_c[EXT_W-1] && (|shr_c[EXT_W-2:WIDTH-1]);
        neg_ovf_c = shr_c[EXT_W-1] && !(&shr_c[EXT_W-2:WIDTH-1]);
        if (pos_ovf_c) begin
            sat_o = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (neg_ovf_c) begin
            sat_o = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat_o = shr_c[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Serial-MAC controller: inserts samples into an external rotating delay line,
// walks the window against a synchronous coefficient ROM and emits one output per input.
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TAPS       = DEF_TAPS,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 40
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    input  logic [WIDTH-1:0]         IN_SAMPLE,
    output logic                     IN_READY,
    output logic [WIDTH-1:0]         SR_D,
    input  logic [WIDTH-1:0]         SR_Q0,
    output logic [$clog2(TAPS)-1:0]  COEF_ADDR,
    input  logic [COEF_WIDTH-1:0]    COEF_DATA,
    output logic                     OUT_VALID,
    output logic [WIDTH-1:0]         OUT_SAMPLE,
    input  logic                     OUT_READY,
    output logic                     BUSY
);

    localparam int unsigned PW     = $clog2(TAPS);
    localparam int unsigned PROD_W = WIDTH + COEF_WIDTH;
    localparam logic [PW-1:0] LAST = PW'(TAPS - 1);

    state_e                        state_q, state_d;
    logic [PW-1:0]                 p_q, p_d;
    logic [PW-1:0]                 addr_q, addr_d;
    logic signed [WIDTH-1:0]       s1_q, s1_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          acc_en_q, acc_en_d;
    logic signed [WIDTH-1:0]       out_q, out_d;
    logic signed [PROD_W-1:0]      prod_c;
    logic signed [WIDTH-1:0]       rs_c;

    assign prod_c     = PROD_W'(s1_q) * PROD_W'($signed(COEF_DATA));
    assign COEF_ADDR  = addr_q;
    assign OUT_SAMPLE = out_q;

    fir_round_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .WIDTH     (WIDTH),
        .SHIFT     (COEF_WIDTH - 1)
    ) u_round_sat (
        .acc_i (acc_q),
        .sat_o (rs_c)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= CLEAR;
            p_q      <= '0;
            addr_q   <= '0;
            s1_q     <= '0;
            acc_q    <= '0;
            acc_en_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            addr_q   <= addr_d;
            s1_q     <= s1_d;
            acc_q    <= acc_d;
            acc_en_q <= acc_en_d;
            out_q    <= out_d;
        end
    end

    // Phase p tracks the line rotation; the accumulate trails each MAC cycle by one to match ROM latency.
    always_comb begin
        state_d   = state_q;
        p_d       = (p_q == LAST) ? '0 : p_q + 1'b1;
        addr_d    = addr_q;
        s1_d      = SR_Q0;
        acc_en_d  = 1'b0;
        acc_d     = acc_en_q ? acc_q + ACC_WIDTH'(prod_c) : acc_q;
        out_d     = out_q;
        SR_D      = SR_Q0;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = 1'b1;

        unique case (state_q)
            CLEAR: begin
                SR_D = '0;
                if (p_q == LAST) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                BUSY     = 1'b0;
                IN_READY = (p_q == '0);
                if (IN_VALID && (p_q == '0)) begin
                    SR_D    = IN_SAMPLE;
                    p_d     = '0;
                    acc_d   = '0;
                    addr_d  = LAST;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_en_d = 1'b1;
                addr_d   = addr_q - 1'b1;
                if (p_q == LAST) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // DRAIN always spans p==0 then p==1; the last product lands during p==0.
                if (p_q == PW'(1)) begin
                    out_d   = rs_c;
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer with a 33-word delay line, a synchronous ROM and a direct-form reference.
module tb_fir_tap_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned T  = 33;
    localparam int unsigned CW = 16;
    localparam int unsigned AW = 40;
    localparam int unsigned PW = $clog2(T);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_sample = '0;
    logic          in_ready;
    logic [W-1:0]  sr_d;
    logic [W-1:0]  sr_q0;
    logic [PW-1:0] coef_addr;
    logic [CW-1:0] coef_data = '0;
    logic          out_valid;
    logic [W-1:0]  out_sample;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          preload = 1'b1;

    logic [W-1:0]  dl  [T];
    logic [CW-1:0] rom [T];
    int            hist [T];
    int            cyc = 0;
    int            last_t = -1;
    int            n_chk = 0;
    int            n_bad = 0;

    fir_tap_sequencer #(
        .WIDTH(W), .TAPS(T), .COEF_WIDTH(CW), .ACC_WIDTH(AW)
    ) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_SAMPLE(in_sample), .IN_READY(in_ready),
        .SR_D(sr_d), .SR_Q0(sr_q0),
        .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .OUT_VALID(out_valid), .OUT_SAMPLE(out_sample), .OUT_READY(out_ready),
        .BUSY(busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < T; i++) dl[i] <= W'($urandom);
        end else begin
            for (int i = 0; i < T - 1; i++) dl[i] <= dl[i+1];
            dl[T-1] <= sr_d;
        end
    end
    assign sr_q0 = dl[0];

    always @(posedge clk) coef_data <= (int'(coef_addr) < T) ? rom[coef_addr] : '0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int j = 0; j < T; j++) hist[j] = 0;
    endfunction

    function automatic void model_push(input int x);
        for (int j = T - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = x;
    endfunction

    // y[n] = sum h[j]*x[n-j], rounded half up and clamped to the sample range.
    function automatic int ref_out();
        longint s = 0;
        longint r;
        for (int j = 0; j < T; j++) s += longint'(hist[j]) * longint'($signed(rom[j]));
        r = (s + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic set_rom_const(input int h0, input int h5, input int rest);
        for (int j = 0; j < T; j++) rom[j] = CW'(rest);
        rom[0] = CW'(h0);
        rom[5] = CW'(h5);
    endtask

    task automatic set_rom_random();
        for (int j = 0; j < T; j++) rom[j] = CW'($urandom_range(0, 8191) - 4096);
    endtask

    task automatic accept(input int x, output int t, output bit ok);
        int waited = 0;
        in_sample = W'(x);
        in_valid  = 1'b1;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        ok = in_ready;
        if (!ok) begin
            chk("in_ready_timeout", longint'(in_ready), 1);
            in_valid = 1'b0;
            t = cyc;
            return;
        end
        t = cyc;
        chk("sr_d_insert", longint'($signed(sr_d)), longint'(x));
        if (last_t >= 0) chk("phase_align", longint'((t - last_t - 1) % T), 0);
        last_t = t;
        model_push(x);
        tick();
        in_valid = 1'b0;
        chk("busy_in_mac", longint'(busy), 1);
    endtask

    task automatic send(input int x, input int bp, output int got);
        int t;
        int exp;
        int waited = 0;
        bit ok;
        logic [W-1:0] held;
        accept(x, t, ok);
        got = 0;
        if (!ok) return;
        exp = ref_out();
        while (!out_valid && waited < 100) begin
            tick();
            waited++;
        end
        chk("latency", longint'(cyc - t), longint'(T + 3));
        got = int'($signed(out_sample));
        chk("out_sample", longint'(got), longint'(exp));
        held = out_sample;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid", longint'(out_valid), 1);
            chk("bp_hold", longint'(out_sample), longint'(held));
            chk("bp_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_drop", longint'(out_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_out_sample"}, longint'(out_sample), 0);
        chk({tag, "_coef_addr"}, longint'(coef_addr), 0);
        chk({tag, "_busy"}, longint'(busy), 1);
        chk({tag, "_sr_d"}, longint'(sr_d), 0);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk(tag, longint'(n), longint'(T));
    endtask

    initial begin
        int got;
        int t;
        int seen;
        bit ok;
        int imp_exp [7];
        imp_exp = '{500, 0, 0, 0, 0, 250, 0};

        model_clear();
        set_rom_random();
        #1;
        tick();
        tick();
        check_reset_outputs("reset");
        preload = 1'b0;
        rst     = 1'b0;
        wait_clear("clear_len");

        // First output after flushing garbage must see an all-zero history.
        send(0, 0, got);
        chk("flush_zero", longint'(got), 0);

        set_rom_const(16'h4000, 16'h2000, 0);
        send(1000, 0, got);
        chk("impulse_0", longint'(got), longint'(imp_exp[0]));
        for (int i = 1; i < 7; i++) begin
            send(0, 0, got);
            chk($sformatf("impulse_%0d", i), longint'(got), longint'(imp_exp[i]));
        end

        set_rom_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < T; i++) send(16384, 0, got);
        chk("sat_33rd", longint'(got), 32767);

        set_rom_const(1, 0, 0);
        send(16384, 0, got);
        chk("round_pos", longint'(got), 1);
        send(-16384, 0, got);
        chk("round_neg_half", longint'(got), 0);
        send(-16385, 0, got);
        chk("round_neg", longint'(got), -1);

        set_rom_random();
        for (int i = 0; i < 3; i++) send(int'($signed(W'($urandom))), 10, got);
        for (int i = 0; i < 20; i++) begin
            send(int'($signed(W'($urandom))), int'($urandom_range(0, 5)), got);
        end

        // Reset in the middle of the MAC walk discards the sample and replays CLEAR.
        set_rom_const(16'h4000, 16'h1234, 16'h0777);
        accept(12345, t, ok);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("midreset_no_out", longint'(seen), 0);
        model_clear();
        last_t = -1;
        send(1000, 0, got);
        chk("midreset_result", longint'(got), 500);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Serial-MAC controller for the CD-DSP FIR stage. It owns the data input of the word-wide tapped delay line: it inserts each accepted sample, then recirculates the line's oldest word (Q[0]) back into its input so the whole window rotates past Q[0] once. During that rotation it multiplies each word by a coefficient from an external synchronous ROM, accumulates, and emits one rounded, saturated output per input sample. The delay line shifts unconditionally every clock, so this block alone keeps the window aligned.

## Interface
- WIDTH, 16: sample width, signed two's complement; must equal the delay-line word width.
- TAPS, 33: filter length; must equal the delay-line depth.
- COEF_WIDTH, 16: coefficient width, signed Q1.(COEF_WIDTH-1).
- ACC_WIDTH, 40: accumulator width; must be ≥ WIDTH+COEF_WIDTH+$clog2(TAPS).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  upstream sample valid.
- IN_SAMPLE  in  WIDTH  upstream sample.
- IN_READY  out  1  sample accepted on IN_VALID && IN_READY.
- SR_D  out  WIDTH  to delay-line D.
- SR_Q0  in  WIDTH  from delay-line Q[0].
- COEF_ADDR  out  $clog2(TAPS)  ROM address; data returns 1 cycle later.
- COEF_DATA  in  COEF_WIDTH  ROM data.
- OUT_VALID  out  1  output sample valid.
- OUT_SAMPLE  out  WIDTH  filtered sample.
- OUT_READY  in  1  downstream ready.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Phase counter p (0..TAPS-1) increments mod TAPS on every clock except the insertion cycle, where it goes to 0. When p==0 (and after insertion), Q[0] holds the oldest window sample.
- SR_D is combinational: 0 in CLEAR; IN_SAMPLE in the insertion cycle; SR_Q0 in all other cycles.
- States:
  - CLEAR: entered on reset. Drives zeros for TAPS cycles to flush the unreset delay line, then goes to IDLE with p=0.
  - IDLE: IN_READY = (p==0). On handshake (the insertion cycle), clear acc, set k=0, go to MAC.
  - MAC: lasts TAPS cycles, k = 0..TAPS-1. COEF_ADDR = TAPS-1-k. s1 <= SR_Q0. Then go to DRAIN.
  - DRAIN: lasts 2 cycles. The final accumulate and the OUT_SAMPLE load complete here.
  - OUTPUT: OUT_VALID=1. On OUT_READY, go to IDLE.
- Accumulate: acc += s1 * COEF_DATA. This runs in the cycle after each MAC cycle, so the ROM latency is absorbed by s1. Result is y[n] = Σ h[j]·x[n-j].
- Output arithmetic:
  - Rounding: add 2^(COEF_WIDTH-2), then arithmetic shift right by COEF_WIDTH-1 (round half up).
  - Saturation: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - OUT_SAMPLE is registered and held stable while OUT_VALID && !OUT_READY.
- Reset values: IN_READY 0, OUT_VALID 0, OUT_SAMPLE 0, COEF_ADDR 0, BUSY 1, SR_D 0, p 0, acc 0.

## Timing
- Handshake in cycle t → MAC cycles t+1..t+TAPS → DRAIN t+TAPS+1..t+TAPS+2 → OUT_VALID from cycle t+TAPS+3. For TAPS=33 this is t+36.
- Minimum input period is 2·TAPS+1 cycles (IDLE waits for p==0). This is far above the CD sample rate at the system clock.
- IN_VALID while not ready: sample held upstream, no effect.
- IN_READY is never high outside IDLE; only one sample is in flight.
- OUT_READY low: stay in OUTPUT. The line keeps rotating and p keeps counting.
- RST asserted in any state: all outputs go to reset values immediately. The partial result is discarded and CLEAR replays after release.
- IN_VALID in the first IDLE cycle after CLEAR (p==0): accepted that cycle.

## Structure
- Package fir_seq_pkg holds:
  - state enum {CLEAR, IDLE, MAC, DRAIN, OUTPUT};
  - PHASE_W = $clog2(TAPS);
  - the rounding constant function.
- One sub-module, fir_round_sat: combinational round + saturate, ACC_WIDTH → WIDTH, parameterised on shift amount.
- The delay line is instantiated beside this block, not inside it.

## Test plan
All scenarios instantiate with a real 33-word delay line and ROM model.
- Reset flush: preload the line with garbage, then reset. IN_READY stays 0 for 33 cycles; the first output for input 0 is 0.
- Impulse: h[0]=0x4000, h[5]=0x2000, others 0. Input 1000 then zeros → outputs 500, 0, 0, 0, 0, 250, 0…
- Latency and saturation: handshake at cycle t → OUT_VALID first at t+36. All h=0x7FFF with repeated 16384 input → 33rd output is 32767.
- Rounding: h[0]=0x0001. Input 16384 → 1; input -16384 → 0; input -16385 → -1.
- Backpressure: OUT_READY low 10 cycles. OUT_SAMPLE is stable and IN_READY is 0. Next input is accepted only at p==0 and the result is still correct.
- Mid-MAC reset: RST at k=10. OUT_VALID never rises for that sample. After CLEAR, input 1000 with h[0]=0x4000 → 500, with history zero.
